// File: rtl/hazard_ctrl_p.sv
// hazard_ctrl_p -- pipeline hazard controller for a five-stage core.
// Produces combinational operand-forward selects for the ID and EX stages
// and a per-stage stall/flush vector from a prioritised hazard FSM. A short
// tail of stall cycles follows every multi-cycle ALU (mul/div) completion.
// Optional feature: define HAZARD_PERF_EN to build a saturating counter of
// cycles in which the fetch stage is stalled. Without it stall_cnt is tied to 0.
module hazard_ctrl_p #(
    parameter int unsigned REG_AW     = 7,
    parameter int unsigned MD_TAIL    = 2,
    parameter logic [1:0]  CP0_PREFIX = 2'b01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exc_req,
    input  logic              if_stall,
    input  logic              mem_stall,
    input  logic              alu_stall,
    input  logic              alu_done,
    input  logic              br_d,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    input  logic [REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0] rt_e,
    input  logic [REG_AW-1:0] wreg_e,
    input  logic [REG_AW-1:0] wreg_m,
    input  logic [REG_AW-1:0] wreg_w,
    input  logic              rw_e,
    input  logic              rw_m,
    input  logic              rw_w,
    input  logic              mr_e,
    input  logic              mr_m,
    output logic [4:0]        stall,
    output logic [3:0]        flush,
    output logic [1:0]        fwd_ad,
    output logic [1:0]        fwd_bd,
    output logic [1:0]        fwd_ae,
    output logic [1:0]        fwd_be,
    output logic [31:0]       stall_cnt
);

    typedef enum logic [3:0] {
        S_RUN, S_EXC, S_EXC_WAIT, S_CP0_W, S_MEM_WAIT,
        S_LD_BR, S_MD_BUSY, S_LD_USE, S_MD_TAIL, S_FE_WAIT
    } state_t;

    // Tail counter preload; a zero-length tail never enters the tail state.
    localparam logic [3:0] TAIL_LOAD = (MD_TAIL == 0) ? 4'd0 : 4'(MD_TAIL - 1);

    state_t     state_q, state_d;
    logic [3:0] tail_q, tail_d;

    // A destination is a CP0 register when its top two tag bits match the prefix.
    function automatic logic is_cp0(input logic [REG_AW-1:0] tag);
        return tag[REG_AW-1 -: 2] == CP0_PREFIX;
    endfunction

    // ---------------- forwarding ----------------
    logic [REG_AW-1:0] src_d [2];
    logic [REG_AW-1:0] src_e [2];
    logic [1:0]        sel_d [2];
    logic [1:0]        sel_e [2];

    assign src_d[0] = rs_d;
    assign src_d[1] = rt_d;
    assign src_e[0] = rs_e;
    assign src_e[1] = rt_e;

    // Tag 0 is the hardwired zero register and is never forwarded.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        assign sel_d[gi] = (rst || src_d[gi] == '0)                ? 2'b00 :
                           (rw_e && mr_e && wreg_e == src_d[gi])   ? 2'b01 :
                           (rw_m && wreg_m == src_d[gi])           ? 2'b10 : 2'b00;
        assign sel_e[gi] = (rst || src_e[gi] == '0)                ? 2'b00 :
                           (rw_m && wreg_m == src_e[gi])           ? 2'b10 :
                           (rw_w && wreg_w == src_e[gi])           ? 2'b01 : 2'b00;
    end

    assign fwd_ad = sel_d[0];
    assign fwd_bd = sel_d[1];
    assign fwd_ae = sel_e[0];
    assign fwd_be = sel_e[1];

    // ---------------- hazard conditions ----------------
    logic cp0_w_hit, ld_br_hit, md_busy_hit, ld_use_hit, md_tail_hit, fe_wait_hit;

    assign cp0_w_hit   = rw_w && is_cp0(wreg_w);
    assign ld_br_hit   = mr_m && rw_m && br_d && (wreg_m == rs_d || wreg_m == rt_d);
    assign md_busy_hit = alu_stall && !alu_done;
    assign ld_use_hit  = (mr_m && rw_m && (wreg_m == rs_e || wreg_m == rt_e)) ||
                         (rw_m && is_cp0(wreg_m));
    assign md_tail_hit = (MD_TAIL != 0) && (state_q == S_MD_BUSY || tail_q != 4'd0);
    assign fe_wait_hit = if_stall ||
                         (mr_e && rw_e && br_d && (wreg_e == rs_d || wreg_e == rt_d)) ||
                         (rw_e && is_cp0(wreg_e));

    // State and tail counter register; reset returns to RUN regardless of inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            tail_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            tail_q  <= tail_d;
        end
    end

    // Prioritised next-state selection and stall/flush decode of the next state.
    always_comb begin
        state_d = S_RUN;
        tail_d  = 4'd0;
        stall   = 5'b00000;
        flush   = 4'b0000;
        if (rst) begin
            state_d = S_RUN;
        end else if (exc_req) begin
            state_d = (if_stall || mem_stall) ? S_EXC_WAIT : S_EXC;
        end else if (cp0_w_hit) begin
            state_d = S_CP0_W;
        end else if (mem_stall) begin
            state_d = S_MEM_WAIT;
        end else if (ld_br_hit) begin
            state_d = S_LD_BR;
        end else if (md_busy_hit) begin
            state_d = S_MD_BUSY;
        end else if (ld_use_hit) begin
            state_d = S_LD_USE;
        end else if (md_tail_hit) begin
            state_d = S_MD_TAIL;
            // Preload on entry, count down while staying; preemption leaves tail_d at 0.
            tail_d  = (state_q == S_MD_TAIL) ? tail_q - 4'd1 : TAIL_LOAD;
        end else if (fe_wait_hit) begin
            state_d = S_FE_WAIT;
        end

        case (state_d)
            S_EXC:      begin stall = 5'b11111; flush = 4'b1111; end
            S_EXC_WAIT: begin stall = 5'b11111; flush = 4'b1110; end
            S_CP0_W:    begin stall = 5'b11110; flush = 4'b0001; end
            S_MEM_WAIT: begin stall = 5'b11111; flush = 4'b0001; end
            S_LD_BR:    begin stall = 5'b11110; flush = 4'b0010; end
            S_MD_BUSY:  begin stall = 5'b11111; flush = 4'b0001; end
            S_LD_USE:   begin stall = 5'b11100; flush = 4'b0010; end
            S_MD_TAIL:  begin stall = 5'b11000; flush = 4'b0100; end
            S_FE_WAIT:  begin stall = 5'b11000; flush = 4'b0100; end
            default:    begin stall = 5'b00000; flush = 4'b0000; end
        endcase
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;

    // Count fetch-stall cycles, holding at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
        end else if (stall[4] && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule
